// File: rtl/fifo_pkg.sv
// Shared types and default widths for the replay FIFO and its read/write engines.
// Used by fifo_reader (optional feature macro: FIFO_RD_PARITY_EN).
package fifo_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer ordered by capture; head is the oldest word.
// Entry width is set by the parent (data plus an optional parity bit).
module fifo_rd_skid #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   cnt,
    output logic [W-1:0] head,
    output logic         valid
);

    logic [W-1:0] entry0;
    logic [W-1:0] entry1;
    logic [1:0]   cnt_q;

    // A simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0 <= '0;
            entry1 <= '0;
            cnt_q  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        entry0 <= push_data;
                    end else if (cnt_q == 2'd1) begin
                        entry1 <= push_data;
                    end
                    if (cnt_q != 2'd2) begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                2'b01: begin
                    entry0 <= entry1;
                    if (cnt_q != 2'd0) begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end else begin
                        entry0 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cnt   = cnt_q;
    assign head  = entry0;
    assign valid = (cnt_q != 2'd0);

endmodule

// File: rtl/fifo_reader.sv
// Read-side engine for the replay FIFO: issues RD, absorbs the 1-cycle read latency
// in a skid buffer and re-presents words on a valid/ready stream. Macro: FIFO_RD_PARITY_EN.
module fifo_reader #(
    parameter int unsigned DATA_W = fifo_pkg::DATA_W,
    parameter int unsigned CNT_W  = fifo_pkg::CNT_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              EN,
    input  logic              start,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic              EMPTY,
    input  logic [DATA_W-1:0] dataOut,
    output logic              RD,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
`ifdef FIFO_RD_PARITY_EN
    output logic              m_parity,
`endif
    output logic [CNT_W-1:0]  word_cnt
);

    import fifo_pkg::*;

`ifdef FIFO_RD_PARITY_EN
    localparam int unsigned SKID_W = DATA_W + 1;
`else
    localparam int unsigned SKID_W = DATA_W;
`endif

    rd_state_t         state;
    rd_state_t         next_state;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  issued_q;
    logic [CNT_W-1:0]  word_cnt_q;
    logic              inflight_q;
    logic              busy_q;
    logic              done_q;
    logic              pop;
    logic [2:0]        occupancy;
    logic [1:0]        skid_cnt;
    logic [SKID_W-1:0] skid_push_data;
    logic [SKID_W-1:0] skid_head;

`ifdef FIFO_RD_PARITY_EN
    assign skid_push_data = {^dataOut, dataOut};
    assign m_parity       = skid_head[DATA_W];
`else
    assign skid_push_data = dataOut;
`endif

    fifo_rd_skid #(
        .W (SKID_W)
    ) u_skid (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .push      (inflight_q),
        .push_data (skid_push_data),
        .pop       (pop),
        .cnt       (skid_cnt),
        .head      (skid_head),
        .valid     (m_valid)
    );

    assign m_data = skid_head[DATA_W-1:0];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = RUN;
            RUN:   if ((len_q != '0 && issued_q == len_q) || (len_q == '0 && EMPTY))
                       next_state = DRAIN;
            DRAIN: if (!inflight_q && skid_cnt == 2'd0) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A word leaving the skid this cycle frees a slot, keeping RD high back-to-back.
    always_comb begin
        pop       = m_valid && m_ready;
        occupancy = 3'(skid_cnt) + 3'(inflight_q) - 3'(pop);
        RD        = (state == RUN) && EN && !EMPTY && (occupancy < 3'd2)
                    && (len_q == '0 || issued_q < len_q);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            len_q      <= '0;
            issued_q   <= '0;
            word_cnt_q <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            inflight_q <= RD;
            busy_q     <= (next_state == RUN) || (next_state == DRAIN);
            done_q     <= (next_state == DONE);
            if (state == IDLE && start) begin
                len_q      <= burst_len;
                issued_q   <= '0;
                word_cnt_q <= '0;
            end else begin
                if (RD)  issued_q   <= issued_q + CNT_W'(1);
                if (pop) word_cnt_q <= word_cnt_q + CNT_W'(1);
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign word_cnt = word_cnt_q;

endmodule
